scan_test_controller: RTL and testbench
=======================================

SCAN_TEST_CONTROLLER -- requirements
Module: scan_test_controller

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 8, meaning the number of scan flops in the controlled chain.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on posedge clk.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to run one test; it is sampled only in IDLE.
REQ-005 The block SHALL have port pattern, input, CHAIN_LEN, the stimulus to load into the chain, bit i targeting chain flop i, with flop 0 driving chain scan_out.
REQ-006 The block SHALL have port expected, input, CHAIN_LEN, the golden capture value.
REQ-007 The block SHALL have port scan_en, output, 1, the chain scan enable.
REQ-008 The block SHALL have port scan_in, output, 1, the serial data into the chain head (flop CHAIN_LEN-1).
REQ-009 The block SHALL have port scan_out, input, 1, the serial data from the chain tail (flop 0).
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse when a test completes.
REQ-012 The block SHALL have port captured, output, CHAIN_LEN, the unloaded chain contents; this port holds its value until the next test completes.
REQ-013 The block SHALL have port pass, output, 1, equal to (captured == expected), valid from done onward and held.
REQ-014 The block SHALL have port pass_cnt, output, 8, a saturating count of passing tests.
REQ-015 The block SHALL have port fail_cnt, output, 8, a saturating count of failing tests.

Function
REQ-016 The block SHALL implement the Moore FSM states IDLE, SHIFT, CAPTURE, UNLOAD and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-017 In IDLE with start=1, the block SHALL latch pattern and expected, clear the bit counter, and go to SHIFT on the next edge.
REQ-018 In SHIFT, the block SHALL hold scan_en=1 for exactly CHAIN_LEN cycles and drive scan_in=pattern_q[k] in the k-th SHIFT cycle, k=0..CHAIN_LEN-1, LSB first; after the last cycle it SHALL go to CAPTURE.
REQ-019 In CAPTURE, the block SHALL drive scan_en=0 and scan_in=0 for exactly one cycle, so that the chain loads its functional data, then go to UNLOAD.
REQ-020 In UNLOAD, the block SHALL hold scan_en=1 and scan_in=0 for CHAIN_LEN cycles; in the j-th UNLOAD cycle it SHALL sample scan_out into captured bit j, LSB first; it SHALL then go to DONE.
REQ-021 In DONE, the block SHALL assert done for one cycle, update pass, increment pass_cnt or fail_cnt (saturating at 255), and return to IDLE.
REQ-022 The latency from the start-accept edge to the done-high cycle SHALL be 2*CHAIN_LEN+2 cycles (18 for CHAIN_LEN=8); back-to-back starts SHALL be accepted one cycle after done.
REQ-023 The block SHALL ignore start while busy; changes on pattern or expected while busy SHALL NOT affect the test in progress.
REQ-024 The bit counter SHALL be $clog2(CHAIN_LEN)+1 bits wide and SHALL NOT wrap within a phase; the terminal count is CHAIN_LEN-1.
REQ-025 Outside SHIFT and UNLOAD, the block SHALL hold scan_en=0; scan_in SHALL be 0 except during SHIFT.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set: state=IDLE, scan_en=0, scan_in=0, busy=0, done=0, captured=0, pass=0, pass_cnt=0, fail_cnt=0, and clear the counter and latched registers.
REQ-027 A reset asserted in any state, including mid-SHIFT or mid-UNLOAD, SHALL abort the test with no done pulse and no counter update; start on the first post-reset cycle SHALL be accepted.

Verification
REQ-028 The bench SHALL cover, with the block driving an 8-flop 4x4 multiplier scan chain: pattern=0x35, expected=0x0F -> captured=0x0F, pass=1, pass_cnt=1, done exactly 18 cycles after start.
REQ-029 The bench SHALL cover: pattern=0xFF, expected=0xE1 -> captured=0xE1, pass=1; then pattern=0x23, expected=0x07 -> captured=0x06, pass=0, fail_cnt=1.
REQ-030 The bench SHALL cover: start pulsed again during UNLOAD -> the extra start is ignored and exactly one done pulse is produced.
REQ-031 The bench SHALL cover: rst asserted in SHIFT cycle 4 -> next cycle scan_en=0, busy=0, no done pulse, counters unchanged at 0.
REQ-032 The bench SHALL cover: start held high continuously for 3 tests -> done pulses exactly 19 cycles apart, and scan_en is low in each CAPTURE cycle.
REQ-033 The bench SHALL cover: 256 failing tests -> fail_cnt saturates at 255 and pass_cnt stays 0.

Source files
------------

// File: rtl/scan_test_controller.sv
// Scan test controller: serially loads a stimulus pattern into a scan chain, pulses one
// functional capture cycle, unloads the response and compares it against a golden value.
module scan_test_controller #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] captured,
  output logic                 pass,
  output logic [7:0]           pass_cnt,
  output logic [7:0]           fail_cnt
);

  localparam int CNT_W = $clog2(CHAIN_LEN) + 1;
  localparam int IDX_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pattern_q;
  logic [CHAIN_LEN-1:0] expected_q;
  logic [CHAIN_LEN-1:0] cap_sr;
  logic [CHAIN_LEN-1:0] cap_nxt;
  logic                 last_bit;

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // All outputs are decoded from registered state, counter and latched pattern only.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    scan_en   = 1'b0;
    scan_in   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        scan_en = 1'b1;
        scan_in = pattern_q[cnt[IDX_W-1:0]];
        if (last_bit) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_UNLOAD;
      S_UNLOAD: begin
        scan_en = 1'b1;
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Response word including the bit being sampled this cycle.
  always_comb begin
    cap_nxt                   = cap_sr;
    cap_nxt[cnt[IDX_W-1:0]]   = scan_out;
  end

  // Result and counters are committed on the last unload edge so they are valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      pattern_q  <= '0;
      expected_q <= '0;
      cap_sr     <= '0;
      captured   <= '0;
      pass       <= 1'b0;
      pass_cnt   <= 8'd0;
      fail_cnt   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pattern_q  <= pattern;
            expected_q <= expected;
            cnt        <= '0;
          end
        end
        S_SHIFT: cnt <= last_bit ? '0 : cnt + CNT_W'(1);
        S_CAPTURE: begin
          cnt    <= '0;
          cap_sr <= '0;
        end
        S_UNLOAD: begin
          cap_sr <= cap_nxt;
          if (last_bit) begin
            cnt      <= '0;
            captured <= cap_nxt;
            pass     <= (cap_nxt == expected_q);
            if (cap_nxt == expected_q) begin
              if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
            end else begin
              if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller driving an 8-flop scan chain around a 4x4 multiplier
// (operands in flops [3:0] and [7:4], product captured into all 8 flops).
module tb_scan_test_controller;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] pattern, expected;
  logic       scan_en, scan_in, scan_out, busy, done, pass;
  logic [7:0] captured, pass_cnt, fail_cnt;

  scan_test_controller #(.CHAIN_LEN(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .expected (expected),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out),
    .busy     (busy),
    .done     (done),
    .captured (captured),
    .pass     (pass),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  // Scan chain under test: shift toward flop 0 when enabled, otherwise capture a*b.
  logic [7:0] chain = 8'h00;
  assign scan_out = chain[0];
  always @(posedge clk) begin
    if (scan_en) chain <= {scan_in, chain[7:1]};
    else         chain <= {4'b0, chain[3:0]} * {4'b0, chain[7:4]};
  end

  int checks = 0;
  int passes = 0;
  int done_count = 0;
  int exp_pc = 0;
  int exp_fc = 0;

  always @(negedge clk) if (done === 1'b1) done_count++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  typedef struct {
    logic [7:0] pat;
    logic [7:0] gold;
    logic [7:0] cap;
    logic       ok;
    string      name;
  } vec_t;

  // Called just after a negedge with the DUT idle; returns one cycle after done.
  task automatic run_test(input vec_t v);
    int n = 0;
    int en_cycles = 0;
    int cap_cycles = 0;
    int bad_si = 0;
    bit got = 0;
    pattern  = v.pat;
    expected = v.gold;
    start    = 1'b1;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start    = 1'b0;
      pattern  = ~v.pat;
      expected = ~v.gold;
      if (done === 1'b1) got = 1;
      else begin
        if (scan_en === 1'b1) en_cycles++;
        else if (busy === 1'b1) cap_cycles++;
        if (n <= 8 && scan_in !== v.pat[n-1]) bad_si++;
      end
    end
    if (v.ok) exp_pc++;
    else      exp_fc++;
    check({v.name, " latency"}, n, 18);
    check({v.name, " scan_en cycles"}, en_cycles, 16);
    check({v.name, " capture cycles"}, cap_cycles, 1);
    check({v.name, " scan_in stream errors"}, bad_si, 0);
    check({v.name, " captured"}, captured, v.cap);
    check({v.name, " pass"}, pass, v.ok);
    check({v.name, " pass_cnt"}, pass_cnt, exp_pc);
    check({v.name, " fail_cnt"}, fail_cnt, exp_fc);
    @(negedge clk);
    check({v.name, " done one cycle"}, done, 1'b0);
    check({v.name, " pass held"}, pass, v.ok);
    check({v.name, " idle after done"}, busy, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   base;
    int   t;
    int   k;
    int   nd;
    int   dt[3];
    logic hist_en[128];
    logic hist_busy[128];

    vecs[0] = '{8'h35, 8'h0F, 8'h0F, 1'b1, "5x3"};
    vecs[1] = '{8'hFF, 8'hE1, 8'hE1, 1'b1, "15x15"};
    vecs[2] = '{8'h23, 8'h07, 8'h06, 1'b0, "3x2 bad gold"};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b1, "0x0"};
    vecs[4] = '{8'hA7, 8'h46, 8'h46, 1'b1, "7x10"};
    vecs[5] = '{8'h5B, 8'h38, 8'h37, 1'b0, "11x5 bad gold"};

    rst = 1'b1; start = 1'b0; pattern = 8'h00; expected = 8'h00;
    repeat (3) @(negedge clk);
    check("reset scan_en", scan_en, 1'b0);
    check("reset scan_in", scan_in, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset captured", captured, 8'h00);
    check("reset pass", pass, 1'b0);
    check("reset pass_cnt", pass_cnt, 8'd0);
    check("reset fail_cnt", fail_cnt, 8'd0);

    // Abort in the fourth SHIFT cycle.
    rst = 1'b0; pattern = 8'h35; expected = 8'h0F; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("shift4 scan_en", scan_en, 1'b1);
    check("shift4 busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("abort scan_en", scan_en, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort pass_cnt", pass_cnt, 8'd0);
    check("abort fail_cnt", fail_cnt, 8'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("abort no done", done_count, 0);

    // Start on the first post-reset cycle, then the vector table.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = done_count;
    for (int i = 0; i < 6; i++) run_test(vecs[i]);
    check("table done pulses", done_count - base, 6);

    // Extra start during UNLOAD is ignored.
    base = done_count;
    pattern = 8'h35; expected = 8'h0F; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("unload phase scan_en", scan_en, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    exp_pc++;
    check("restart ignored done pulses", done_count - base, 1);
    check("restart ignored pass_cnt", pass_cnt, exp_pc);
    check("restart ignored idle", busy, 1'b0);

    // start held high across three tests.
    pattern = 8'h35; expected = 8'h0F; start = 1'b1;
    t = 0; k = 0;
    while (k < 3 && t < 100) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      hist_en[t]   = scan_en;
      hist_busy[t] = busy;
      if (done === 1'b1) begin
        dt[k] = t;
        k++;
      end
    end
    start = 1'b0;
    check("held start done count", k, 3);
    if (k == 3) begin
      check("held start first latency", dt[0], 18);
      check("held start gap 1", dt[1] - dt[0], 19);
      check("held start gap 2", dt[2] - dt[1], 19);
    end
    for (int i = 0; i < k; i++) begin
      if (dt[i] >= 10) begin
        check("held start capture scan_en", hist_en[dt[i]-9], 1'b0);
        check("held start capture busy", hist_busy[dt[i]-9], 1'b1);
        check("held start last shift scan_en", hist_en[dt[i]-10], 1'b1);
      end
    end
    exp_pc += 3;
    check("held start pass_cnt", pass_cnt, exp_pc);

    // 256 failing tests saturate fail_cnt.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pattern = 8'h23; expected = 8'h07; start = 1'b1;
    t = 0; nd = 0;
    while (nd < 256 && t < 6000) begin
      @(negedge clk);
      t++;
      if (done === 1'b1) begin
        nd++;
        if (nd == 254) check("fail_cnt at 254", fail_cnt, 8'd254);
        if (nd == 255) check("fail_cnt at 255", fail_cnt, 8'd255);
      end
    end
    start = 1'b0;
    check("saturation test count", nd, 256);
    check("fail_cnt saturated", fail_cnt, 8'd255);
    check("pass_cnt stays zero", pass_cnt, 8'd0);

    repeat (25) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
